// File: rtl/sva_result_collector.sv
// Collects SVA checker event pulses over a start/stop run window and presents
// a final verdict through a valid/ready report handshake once the checker is idle.
module sva_result_collector #(
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned PERIOD_WIDTH = 16,
    parameter int unsigned FAIL_LIMIT   = 1
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    gclk_posedge_flag,
    input  logic                    busy,
    input  logic                    succ,
    input  logic                    fail,
    input  logic                    lazy_succ,
    output logic [CNT_WIDTH-1:0]    succ_cnt,
    output logic [CNT_WIDTH-1:0]    fail_cnt,
    output logic [CNT_WIDTH-1:0]    lazy_cnt,
    output logic [PERIOD_WIDTH-1:0] period_cnt,
    output logic                    first_fail_valid,
    output logic [PERIOD_WIDTH-1:0] first_fail_period,
    output logic                    abort,
    output logic                    report_valid,
    input  logic                    report_ready,
    output logic [1:0]              verdict
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StReport} state_e;

    localparam logic [CNT_WIDTH-1:0] CntMax   = '1;
    localparam logic [CNT_WIDTH-1:0] LimitVal = CNT_WIDTH'(FAIL_LIMIT);

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    succ_d, fail_d, lazy_d;
    logic [PERIOD_WIDTH-1:0] period_d, first_fail_period_d;
    logic                    first_fail_valid_d, abort_d, report_valid_d;
    logic [1:0]              verdict_d;
    logic                    clear, count;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic en);
        return (en && (v != CntMax)) ? v + 1'b1 : v;
    endfunction

    always_comb begin
        state_d             = state_q;
        succ_d              = succ_cnt;
        fail_d              = fail_cnt;
        lazy_d              = lazy_cnt;
        period_d            = period_cnt;
        first_fail_valid_d  = first_fail_valid;
        first_fail_period_d = first_fail_period;
        abort_d             = abort;
        report_valid_d      = 1'b0;
        verdict_d           = 2'b00;
        clear               = 1'b0;
        count               = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (start) begin
                    clear = 1'b1;
                end else begin
                    count = 1'b1;
                    if (gclk_posedge_flag) period_d = period_cnt + 1'b1;
                    if (stop) state_d = StDrain;
                end
            end
            StDrain: begin
                count = 1'b1;
                if (!busy) state_d = StReport;
            end
            StReport: begin
                if (report_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (clear) begin
            succ_d              = '0;
            fail_d              = '0;
            lazy_d              = '0;
            period_d            = '0;
            first_fail_valid_d  = 1'b0;
            first_fail_period_d = '0;
            abort_d             = 1'b0;
        end

        if (count) begin
            succ_d = sat_inc(succ_cnt, succ);
            fail_d = sat_inc(fail_cnt, fail);
            lazy_d = sat_inc(lazy_cnt, lazy_succ);
            // Capture uses the pre-increment period so a coincident edge is not counted.
            if (fail && !first_fail_valid) begin
                first_fail_valid_d  = 1'b1;
                first_fail_period_d = period_cnt;
            end
        end

        if ((state_q == StRun) && !start && (FAIL_LIMIT != 0) && (fail_d >= LimitVal)) begin
            abort_d = 1'b1;
            state_d = StDrain;
        end

        if (state_d == StReport) begin
            report_valid_d = 1'b1;
            if (fail_d != '0) begin
                verdict_d = 2'b10;
            end else if ((succ_d != '0) || (lazy_d != '0)) begin
                verdict_d = 2'b01;
            end else begin
                verdict_d = 2'b11;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q           <= StIdle;
            succ_cnt          <= '0;
            fail_cnt          <= '0;
            lazy_cnt          <= '0;
            period_cnt        <= '0;
            first_fail_valid  <= 1'b0;
            first_fail_period <= '0;
            abort             <= 1'b0;
            report_valid      <= 1'b0;
            verdict           <= 2'b00;
        end else begin
            state_q           <= state_d;
            succ_cnt          <= succ_d;
            fail_cnt          <= fail_d;
            lazy_cnt          <= lazy_d;
            period_cnt        <= period_d;
            first_fail_valid  <= first_fail_valid_d;
            first_fail_period <= first_fail_period_d;
            abort             <= abort_d;
            report_valid      <= report_valid_d;
            verdict           <= verdict_d;
        end
    end

endmodule

// File: tb/tb_sva_result_collector.sv
// Directed and randomized checks of sva_result_collector against a behavioural
// run/drain/report model with small counter widths to reach saturation and wrap.
module tb_sva_result_collector;

    localparam int CW   = 4;
    localparam int PW   = 3;
    localparam int FL   = 2;
    localparam int CMAX = (1 << CW) - 1;
    localparam int PMOD = 1 << PW;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_DRAIN  = 2;
    localparam int M_REPORT = 3;

    logic          sys_clk = 1'b0;
    logic          sys_rst, start, stop, gclk_posedge_flag, busy;
    logic          succ, fail, lazy_succ, report_ready;
    logic [CW-1:0] succ_cnt, fail_cnt, lazy_cnt;
    logic [PW-1:0] period_cnt, first_fail_period;
    logic          first_fail_valid, abort, report_valid;
    logic [1:0]    verdict;

    int checks   = 0;
    int failures = 0;
    string phase = "init";

    int m_mode, m_succ, m_fail, m_lazy, m_per, m_ffv, m_ffp, m_abort;

    sva_result_collector #(
        .CNT_WIDTH   (CW),
        .PERIOD_WIDTH(PW),
        .FAIL_LIMIT  (FL)
    ) dut (
        .sys_clk          (sys_clk),
        .sys_rst          (sys_rst),
        .start            (start),
        .stop             (stop),
        .gclk_posedge_flag(gclk_posedge_flag),
        .busy             (busy),
        .succ             (succ),
        .fail             (fail),
        .lazy_succ        (lazy_succ),
        .succ_cnt         (succ_cnt),
        .fail_cnt         (fail_cnt),
        .lazy_cnt         (lazy_cnt),
        .period_cnt       (period_cnt),
        .first_fail_valid (first_fail_valid),
        .first_fail_period(first_fail_period),
        .abort            (abort),
        .report_valid     (report_valid),
        .report_ready     (report_ready),
        .verdict          (verdict)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input int unsigned exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s/%s got=%0d exp=%0d", phase, tag, got, exp);
        end
    endtask

    function automatic int sat1(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic m_clear();
        m_succ = 0; m_fail = 0; m_lazy = 0; m_per = 0;
        m_ffv = 0; m_ffp = 0; m_abort = 0;
    endtask

    task automatic m_events();
        if (fail && m_ffv == 0) begin
            m_ffv = 1;
            m_ffp = m_per;
        end
        if (succ) m_succ = sat1(m_succ);
        if (fail) m_fail = sat1(m_fail);
        if (lazy_succ) m_lazy = sat1(m_lazy);
    endtask

    task automatic model_step();
        if (sys_rst) begin
            m_clear();
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: if (start) begin m_clear(); m_mode = M_RUN; end
                M_RUN: begin
                    if (start) begin
                        m_clear();
                    end else begin
                        m_events();
                        if (gclk_posedge_flag) m_per = (m_per + 1) % PMOD;
                        if (stop) m_mode = M_DRAIN;
                        if (FL != 0 && m_fail >= FL) begin
                            m_abort = 1;
                            m_mode  = M_DRAIN;
                        end
                    end
                end
                M_DRAIN: begin
                    m_events();
                    if (!busy) m_mode = M_REPORT;
                end
                default: if (report_ready) m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic check_all();
        int exp_v;
        exp_v = 0;
        if (m_mode == M_REPORT) exp_v = (m_fail != 0) ? 2 : ((m_succ + m_lazy) != 0) ? 1 : 3;
        chk("succ_cnt", 32'(succ_cnt), m_succ);
        chk("fail_cnt", 32'(fail_cnt), m_fail);
        chk("lazy_cnt", 32'(lazy_cnt), m_lazy);
        chk("period_cnt", 32'(period_cnt), m_per);
        chk("ff_valid", 32'(first_fail_valid), m_ffv);
        chk("ff_period", 32'(first_fail_period), m_ffp);
        chk("abort", 32'(abort), m_abort);
        chk("report_valid", 32'(report_valid), (m_mode == M_REPORT) ? 1 : 0);
        chk("verdict", 32'(verdict), exp_v);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        model_step();
        #1;
        check_all();
        start = 0; stop = 0; succ = 0; fail = 0; lazy_succ = 0; gclk_posedge_flag = 0;
    endtask

    initial begin
        sys_rst = 1; start = 0; stop = 0; gclk_posedge_flag = 0; busy = 0;
        succ = 0; fail = 0; lazy_succ = 0; report_ready = 0;
        m_clear();
        m_mode = M_IDLE;

        phase = "reset";
        tick(); tick();
        chk("rst_verdict", 32'(verdict), 0);
        chk("rst_valid", 32'(report_valid), 0);
        sys_rst = 0;
        tick();

        phase = "basic";
        start = 1; tick();
        gclk_posedge_flag = 1; succ = 1; tick();
        gclk_posedge_flag = 1; tick();
        gclk_posedge_flag = 1; lazy_succ = 1; tick();
        succ = 1; tick();
        busy = 0; report_ready = 1; stop = 1; tick();
        chk("drain_valid", 32'(report_valid), 0);
        tick();
        chk("rep_valid", 32'(report_valid), 1);
        chk("rep_verdict", 32'(verdict), 1);
        chk("rep_succ", 32'(succ_cnt), 2);
        chk("rep_lazy", 32'(lazy_cnt), 1);
        chk("rep_period", 32'(period_cnt), 3);
        tick();
        chk("valid_drop", 32'(report_valid), 0);
        report_ready = 0;

        phase = "abort";
        start = 1; tick();
        repeat (4) begin gclk_posedge_flag = 1; tick(); end
        fail = 1; tick();
        chk("abort_early", 32'(abort), 0);
        repeat (2) begin gclk_posedge_flag = 1; tick(); end
        fail = 1; tick();
        chk("abort_set", 32'(abort), 1);
        chk("ff_period4", 32'(first_fail_period), 4);
        tick();
        chk("abort_verdict", 32'(verdict), 2);
        report_ready = 1; tick(); report_ready = 0;

        phase = "drain";
        start = 1; tick();
        busy = 1; stop = 1; tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) fail = 1;
            tick();
            chk("deferred", 32'(report_valid), 0);
        end
        busy = 0; tick();
        chk("drain_fail", 32'(fail_cnt), 1);
        chk("drain_verdict", 32'(verdict), 2);
        report_ready = 1; tick(); report_ready = 0;

        phase = "saturate";
        start = 1; tick();
        succ = 1; fail = 1; lazy_succ = 1; tick();
        chk("tri_succ", 32'(succ_cnt), 1);
        chk("tri_fail", 32'(fail_cnt), 1);
        chk("tri_lazy", 32'(lazy_cnt), 1);
        for (int i = 0; i < 20; i++) begin
            succ = 1;
            gclk_posedge_flag = (i < 10);
            tick();
        end
        chk("sat_succ", 32'(succ_cnt), 15);
        chk("wrap_period", 32'(period_cnt), 2);
        stop = 1; tick(); tick();
        report_ready = 1; tick(); report_ready = 0;

        phase = "vacuous";
        start = 1; tick();
        stop = 1; tick(); tick();
        chk("vac_verdict", 32'(verdict), 3);
        repeat (3) begin
            tick();
            chk("hold_valid", 32'(report_valid), 1);
            chk("hold_verdict", 32'(verdict), 3);
        end
        report_ready = 1; tick(); report_ready = 0;

        phase = "restart";
        start = 1; tick();
        succ = 1; tick();
        gclk_posedge_flag = 1; tick();
        chk("pre_restart", 32'(succ_cnt), 1);
        start = 1; succ = 1; tick();
        chk("restart_succ", 32'(succ_cnt), 0);
        chk("restart_period", 32'(period_cnt), 0);
        stop = 1; tick(); tick();
        chk("restart_verdict", 32'(verdict), 3);
        report_ready = 1; tick(); report_ready = 0;

        phase = "rst_drain";
        start = 1; tick();
        succ = 1; tick();
        busy = 1; stop = 1; tick();
        sys_rst = 1; tick();
        chk("rst_succ", 32'(succ_cnt), 0);
        chk("rst_valid2", 32'(report_valid), 0);
        sys_rst = 0; busy = 0;
        tick(); tick();
        chk("no_report", 32'(report_valid), 0);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            sys_rst           = ($urandom_range(199) == 0);
            start             = ($urandom_range(39) == 0);
            stop              = ($urandom_range(24) == 0);
            succ              = ($urandom_range(3) == 0);
            fail              = ($urandom_range(5) == 0);
            lazy_succ         = ($urandom_range(3) == 0);
            gclk_posedge_flag = ($urandom_range(2) == 0);
            busy              = ($urandom_range(1) == 0);
            report_ready      = ($urandom_range(2) == 0);
            tick();
        end
        sys_rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
